// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 3-bit CPU datapath.
// Owns the PC, instruction register, flag register and retired count; handshakes with imem/dmem.
module cpu_seq_ctrl #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 10,
    parameter int DATA_W  = 3,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic                 dmem_req,
    output logic [PC_W-1:0]      dmem_addr,
    input  logic                 dmem_ack,
    input  logic                 alu_zf,
    input  logic                 alu_sf,
    input  logic                 alu_cf,
    output logic [1:0]           alu_op,
    output logic                 imm_sel,
    output logic                 ld_sel,
    output logic                 reg_we,
    output logic [INSTR_W-5:0]   operand,
    output logic [PC_W-1:0]      pc,
    output logic [2:0]           flags,
    output logic [CNT_W-1:0]     retired,
    output logic                 busy,
    output logic                 halted
);

    // state  | meaning
    // IDLE   | waiting for start, nothing in flight
    // FETCH  | imem_req held until imem_ack loads IR
    // DECODE | one cycle, choose HALT / MEM / EXEC from opcode
    // EXEC   | ALU selects valid, flags captured unless opcode is 01xx
    // MEM    | dmem_req held until dmem_ack
    // WB     | register write, PC update (jump or +1), retire count
    // HALT   | absorbing, only rst leaves

    localparam int OP_W   = 4;
    localparam int OPND_W = INSTR_W - OP_W;

    // The jump target and load address are taken from the low operand bits.
    generate
        if (OPND_W < PC_W || DATA_W < 1) begin : g_bad_params
            $error("cpu_seq_ctrl: operand narrower than PC or empty datapath");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [PC_W-1:0]     pc_q;
    logic [2:0]          flags_q;
    logic [CNT_W-1:0]    retired_q;

    logic [OP_W-1:0]     opcode;
    logic [OPND_W-1:0]   opnd;
    logic                zf_q;
    logic                sf_q;
    logic                is_jump;
    logic                jump_taken;
    logic                no_write;

    assign opcode     = ir[INSTR_W-1 -: OP_W];
    assign opnd       = ir[OPND_W-1:0];
    assign zf_q       = flags_q[0];
    assign sf_q       = flags_q[1];
    assign is_jump    = (opcode == 4'b0100);
    assign jump_taken = is_jump && zf_q && !sf_q;
    assign no_write   = (opcode == 4'b0001) || (opcode == 4'b1101) || (opcode[3:2] == 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ir        <= '0;
            pc_q      <= '0;
            flags_q   <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc_q  <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == 4'b1111)
                        state <= S_HALT;
                    else if (opcode == 4'b1000)
                        state <= S_MEM;
                    else
                        state <= S_EXEC;
                end
                S_EXEC: begin
                    if (opcode[3:2] != 2'b01)
                        flags_q <= {alu_cf, alu_sf, alu_zf};
                    state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ack)
                        state <= S_WB;
                end
                S_WB: begin
                    if (jump_taken)
                        pc_q <= opnd[PC_W-1:0];
                    else
                        pc_q <= pc_q + PC_W'(1);
                    if (retired_q != '1)
                        retired_q <= retired_q + CNT_W'(1);
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Every output below is a decode of registered state/IR, so an async reset
    // clears the request strobes without waiting for a clock edge.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state == S_MEM);
    assign dmem_addr = opnd[PC_W-1:0];
    assign alu_op    = opcode[1:0];
    assign imm_sel   = (opcode[3:2] == 2'b00);
    assign ld_sel    = (opcode == 4'b1000);
    assign reg_we    = (state == S_WB) && !no_write;
    assign operand   = opnd;
    assign pc        = pc_q;
    assign flags     = flags_q;
    assign retired   = retired_q;
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: small imem/dmem responders and hand-computed expectations.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_ack;
    logic [9:0]  imem_rdata;
    logic        dmem_req;
    logic [3:0]  dmem_addr;
    logic        dmem_ack;
    logic        alu_zf;
    logic        alu_sf;
    logic        alu_cf;
    logic [1:0]  alu_op;
    logic        imm_sel;
    logic        ld_sel;
    logic        reg_we;
    logic [5:0]  operand;
    logic [3:0]  pc;
    logic [2:0]  flags;
    logic [7:0]  retired;
    logic        busy;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] prog [16];
    int  imem_wait = 0;
    int  dmem_wait = 0;
    int  iw_cnt = 0;
    int  dw_cnt = 0;
    bit  spurious_iack = 1'b0;

    cpu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_ack   (dmem_ack),
        .alu_zf     (alu_zf),
        .alu_sf     (alu_sf),
        .alu_cf     (alu_cf),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .ld_sel     (ld_sel),
        .reg_we     (reg_we),
        .operand    (operand),
        .pc         (pc),
        .flags      (flags),
        .retired    (retired),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Memory responders act on the falling edge so the DUT sees stable acks at the rising edge.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (iw_cnt >= imem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = prog[imem_addr];
                end else begin
                    imem_ack = 1'b0;
                    iw_cnt++;
                end
            end else begin
                imem_ack = spurious_iack;
                iw_cnt   = 0;
            end
            if (dmem_req) begin
                if (dw_cnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                end else begin
                    dmem_ack = 1'b0;
                    dw_cnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                dw_cnt   = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic cf, input logic sf, input logic zf);
        alu_cf = cf;
        alu_sf = sf;
        alu_zf = zf;
    endtask

    // Runs a 4-cycle non-load instruction from FETCH to the next FETCH, checking reg_we each cycle.
    task automatic run_alu(input string tag, input logic exp_we);
        step();
        check({tag, "_we_dec"}, reg_we, 1'b0);
        step();
        check({tag, "_we_exec"}, reg_we, 1'b0);
        step();
        check({tag, "_we_wb"}, reg_we, exp_we);
        step();
        check({tag, "_we_fetch"}, reg_we, 1'b0);
        check({tag, "_req_fetch"}, imem_req, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 10'b0000_000000;
        prog[0]  = 10'b0010_000000;
        prog[1]  = 10'b1000_000101;
        prog[2]  = 10'b0011_000000;
        prog[3]  = 10'b0100_000111;
        prog[7]  = 10'b0000_000000;
        prog[8]  = 10'b0100_000111;
        prog[9]  = 10'b0001_000000;
        prog[10] = 10'b1101_000000;
        prog[11] = 10'b0110_000000;
        prog[12] = 10'b0100_001111;
        prog[15] = 10'b0010_000000;

        rst   = 1'b1;
        start = 1'b0;
        set_alu(1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_pc", pc, 4'd0);
        check("rst_flags", flags, 3'b000);
        check("rst_retired", retired, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_ireq", imem_req, 1'b0);
        check("rst_dreq", dmem_req, 1'b0);
        check("rst_we", reg_we, 1'b0);
        rst = 1'b0;
        step();
        check("idle_ireq", imem_req, 1'b0);

        // Instruction 0: 0010 ALU op, zero-wait fetch
        set_alu(1'b1, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("i0_ireq", imem_req, 1'b1);
        check("i0_iaddr", imem_addr, 4'd0);
        check("i0_busy", busy, 1'b1);
        step();
        check("i0_dec_we", reg_we, 1'b0);
        check("i0_dec_ireq", imem_req, 1'b0);
        step();
        check("i0_alu_op", alu_op, 2'b10);
        check("i0_imm_sel", imm_sel, 1'b1);
        check("i0_exec_we", reg_we, 1'b0);
        step();
        check("i0_wb_we", reg_we, 1'b1);
        check("i0_flags", flags, 3'b100);
        step();
        check("i0_pc", pc, 4'd1);
        check("i0_retired", retired, 8'd1);
        check("i0_next_we", reg_we, 1'b0);
        check("i0_next_iaddr", imem_addr, 4'd1);

        // Instruction 1: load with three dmem wait cycles
        dmem_wait = 3;
        step();
        check("ld_dec_dreq", dmem_req, 1'b0);
        step();
        check("ld_dreq0", dmem_req, 1'b1);
        check("ld_daddr", dmem_addr, 4'b0101);
        check("ld_sel_mem", ld_sel, 1'b1);
        check("ld_we_mem", reg_we, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step();
            check($sformatf("ld_dreq%0d", k), dmem_req, 1'b1);
        end
        step();
        check("ld_dreq_wb", dmem_req, 1'b0);
        check("ld_we_wb", reg_we, 1'b1);
        check("ld_sel_wb", ld_sel, 1'b1);
        check("ld_flags", flags, 3'b100);
        step();
        check("ld_we_after", reg_we, 1'b0);
        check("ld_pc", pc, 4'd2);
        check("ld_retired", retired, 8'd2);
        dmem_wait = 0;

        // Instruction 2: ALU op sets zf=1, sf=0
        set_alu(1'b0, 1'b0, 1'b1);
        run_alu("i2", 1'b1);
        check("i2_flags", flags, 3'b001);
        check("i2_pc", pc, 4'd3);

        // Jump 0100_000111 taken; ALU flag inputs must not be captured
        set_alu(1'b1, 1'b1, 1'b0);
        run_alu("jt", 1'b0);
        check("jt_pc", pc, 4'd7);
        check("jt_flags", flags, 3'b001);
        check("jt_retired", retired, 8'd4);

        // ALU op with sf=1, then the same jump is not taken
        set_alu(1'b0, 1'b1, 1'b1);
        run_alu("i7", 1'b1);
        check("i7_flags", flags, 3'b011);
        check("i7_pc", pc, 4'd8);
        set_alu(1'b0, 1'b0, 1'b0);
        run_alu("jn", 1'b0);
        check("jn_pc", pc, 4'd9);
        check("jn_flags", flags, 3'b011);
        check("jn_retired", retired, 8'd6);

        // Non-writing opcodes 0001, 1101, 0110
        set_alu(1'b0, 1'b0, 1'b0);
        run_alu("op0001", 1'b0);
        check("op0001_flags", flags, 3'b000);
        check("op0001_ret", retired, 8'd7);
        set_alu(1'b0, 1'b0, 1'b1);
        run_alu("op1101", 1'b0);
        check("op1101_flags", flags, 3'b001);
        check("op1101_ret", retired, 8'd8);
        set_alu(1'b1, 1'b1, 1'b0);
        run_alu("op0110", 1'b0);
        check("op0110_flags", flags, 3'b001);
        check("op0110_ret", retired, 8'd9);
        check("op0110_pc", pc, 4'd12);

        // Jump to 15, then a non-jump wraps the PC to 0
        run_alu("j15", 1'b0);
        check("j15_pc", pc, 4'd15);
        set_alu(1'b0, 1'b0, 1'b0);
        run_alu("wrap", 1'b1);
        check("wrap_pc", pc, 4'd0);
        check("wrap_retired", retired, 8'd11);

        // Halt opcode, then start and stray imem acks are ignored
        prog[0] = 10'b1111_000000;
        step();
        step();
        check("halt_halted", halted, 1'b1);
        check("halt_busy", busy, 1'b0);
        start = 1'b1;
        spurious_iack = 1'b1;
        repeat (4) step();
        start = 1'b0;
        spurious_iack = 1'b0;
        step();
        check("halt_pc", pc, 4'd0);
        check("halt_retired", retired, 8'd11);
        check("halt_still", halted, 1'b1);
        check("halt_ireq", imem_req, 1'b0);
        check("halt_flags", flags, 3'b000);

        // Reset asserted mid-fetch drops imem_req without a clock edge
        rst = 1'b1;
        step();
        rst = 1'b0;
        prog[0] = 10'b0010_000000;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rf_ireq_before", imem_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("rf_ireq_async", imem_req, 1'b0);
        check("rf_retired", retired, 8'd0);
        check("rf_halted", halted, 1'b0);
        check("rf_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_iaddr", imem_addr, 4'd0);
        check("rs_ireq", imem_req, 1'b1);
        set_alu(1'b0, 1'b0, 1'b1);
        run_alu("rs", 1'b1);
        check("rs_pc", pc, 4'd1);
        check("rs_retired", retired, 8'd1);
        check("rs_flags", flags, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the 3-bit CPU datapath. It steps each instruction through fetch, decode, execute or memory, then writeback. It owns the PC, the instruction register and the flag register, and it issues req/ack handshakes to instruction and data memory. It drives the datapath selects (alu_op, imm_sel, ld_sel, reg_we) with the same opcode semantics as the existing decode logic.

Parameters:
PC_W, 4, program counter / instruction address width
INSTR_W, 10, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4], operand = remaining low bits
DATA_W, 3, datapath width; carried for bench consistency, no internal use beyond address truncation
CNT_W, 8, retired-instruction counter width

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  leave IDLE and begin execution at PC=0
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
dmem_req  out  1  data load request
dmem_addr  out  PC_W  load address = operand[PC_W-1:0]
dmem_ack  in  1  load data present on datapath this cycle
alu_zf  in  1  ALU zero flag
alu_sf  in  1  ALU sign flag
alu_cf  in  1  ALU carry flag
alu_op  out  2  opcode[1:0] from IR
imm_sel  out  1  opcode[3:2]==00
ld_sel  out  1  opcode==1000
reg_we  out  1  register-file write strobe
operand  out  INSTR_W-4  IR operand field
pc  out  PC_W  current PC
flags  out  3  {cf_q, sf_q, zf_q}
retired  out  CNT_W  retired-instruction count
busy  out  1  state is not IDLE and not HALT
halted  out  1  state == HALT

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are Moore-decoded from registered state plus IR; none depend combinationally on ack inputs.
- Reset (async) puts every register to a fixed value: state=IDLE, pc=0, IR=0, flags=000, retired=0. Consequences: all strobes are 0 and busy=halted=0. Reset mid-transaction drops imem_req/dmem_req immediately.
- IDLE: start=1 -> FETCH with pc=0. Otherwise stay.
- FETCH: imem_req=1, held until imem_ack. On the ack edge IR<=imem_rdata and the state goes to DECODE. Fetch latency is 1+N cycles for N wait cycles.
- DECODE: one cycle. opcode 1111 -> HALT. opcode 1000 -> MEM. Any other opcode -> EXEC.
- EXEC: one cycle. alu_op and imm_sel are valid. If opcode[3:2]!=01, flags <= {alu_cf, alu_sf, alu_zf} at the end of the cycle. Next state WB.
- MEM: dmem_req=1 and ld_sel=1, held until dmem_ack. The ack cycle goes to WB.
- WB: one cycle.
  - reg_we=1 unless opcode is 0001, 1101 or 01xx.
  - Register-file write for a load occurs here, with ld_sel still asserted.
  - Jump taken when opcode==0100 and zf_q==1 and sf_q==0. Flags are the registered values from earlier instructions, because 0100 does not update flags.
  - Taken: pc <= operand[PC_W-1:0]. Not taken: pc <= pc+1, wrapping 2^PC_W-1 -> 0.
  - retired <= retired+1, saturating at all-ones.
  - Next state FETCH.
- HALT: absorbing. start is ignored and only rst exits. pc, flags and retired are frozen.
- Acks arriving while the matching req is low are ignored. start outside IDLE is ignored.
- Minimum cycles per instruction with zero-wait memory: ALU op 4 (F,D,E,W); load 4 (F,D,M,W).

Test Plan:
- Reset then start=1 pulse with zero-wait imem: imem_addr=0 in the first FETCH cycle. Instruction 0010_xxxxxx gives alu_op=10, imm_sel=1, reg_we=1 in WB only, pc=1, retired=1 after 4 cycles.
- Load 1000_000101 with dmem_ack delayed 3 cycles: dmem_req high 4 cycles, dmem_addr=0101, ld_sel=1 through WB, reg_we=1 for one cycle, pc advances by 1.
- Flags set zf=1, sf=0 by an ALU op, then 0100_000111: pc=0111 after WB and flags unchanged. Repeat with alu_sf=1 during the earlier EXEC: pc increments.
- Opcodes 0001, 1101, 0110: reg_we stays 0 in every cycle, and retired still increments.
- pc=1111 with a non-jump instruction: pc wraps to 0000. 1111 opcode: halted=1, busy=0, and further start/imem_ack pulses leave pc and retired unchanged.
- Assert rst during FETCH with imem_req=1: imem_req drops in the same cycle with no clock edge, and all outputs read reset values. After release and start, fetch resumes from pc=0.
